// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle ARM-subset datapath. Walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath controls.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic [3:0]         rd,
  input  logic               mem_ready,
  output logic               irWrite,
  output logic               nextPC,
  output logic               adrSrc,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluControl,
  output logic [1:0]         resultSrc,
  output logic [1:0]         immSrc,
  output logic [1:0]         regSrc,
  output logic               pcs,
  output logic               regW,
  output logic               memW,
  output logic [1:0]         flagW,
  output logic               illegal,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXECR  = STATE_W'(6),
    EXECI  = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9)
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       supported;
    logic       arith;
    logic       is_cmp;
    logic [1:0] alu_op;
  } dp_decode_t;

  state_e     state_q, state_d;
  dp_decode_t dp;
  logic       imm_bit;
  logic       s_bit;
  logic [3:0] cmd;
  logic       rd_is_pc;

  // Enables before reset gating; rst forces every one of them low.
  logic       ir_write_raw;
  logic       next_pc_raw;
  logic       pcs_raw;
  logic       reg_w_raw;
  logic       mem_w_raw;
  logic [1:0] flag_w_raw;
  logic       illegal_raw;
  logic       done_raw;

  assign imm_bit  = funct[5];
  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign rd_is_pc = (rd == 4'd15);

  always_comb begin : dp_cmd_decode
    dp = '0;
    case (cmd)
      CMD_ADD: dp = '{supported: 1'b1, arith: 1'b1, is_cmp: 1'b0, alu_op: ALU_ADD};
      CMD_SUB: dp = '{supported: 1'b1, arith: 1'b1, is_cmp: 1'b0, alu_op: ALU_SUB};
      CMD_AND: dp = '{supported: 1'b1, arith: 1'b0, is_cmp: 1'b0, alu_op: ALU_AND};
      CMD_ORR: dp = '{supported: 1'b1, arith: 1'b0, is_cmp: 1'b0, alu_op: ALU_ORR};
      CMD_CMP: dp = '{supported: 1'b1, arith: 1'b1, is_cmp: 1'b1, alu_op: ALU_SUB};
      default: dp = '0;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin : next_state_and_outputs
    state_d      = state_q;
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    adrSrc       = 1'b0;
    aluSrcA      = 1'b0;
    aluSrcB      = SRCB_RM;
    aluControl   = ALU_ADD;
    resultSrc    = RES_ALUOUT;
    pcs_raw      = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    flag_w_raw   = 2'b00;
    illegal_raw  = 1'b0;
    done_raw     = 1'b0;

    case (state_q)
      FETCH: begin
        aluSrcA      = 1'b1;
        aluSrcB      = SRCB_FOUR;
        resultSrc    = RES_ALU;
        ir_write_raw = mem_ready;
        next_pc_raw  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end

      DECODE: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU;
        case (op)
          OP_DP: begin
            if (dp.supported) begin
              state_d = imm_bit ? EXECI : EXECR;
            end else begin
              illegal_raw = 1'b1;
              state_d     = FETCH;
            end
          end
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: begin
            illegal_raw = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end

      EXECR, EXECI: begin
        aluSrcB    = (state_q == EXECI) ? SRCB_IMM : SRCB_RM;
        aluControl = dp.alu_op;
        // Compare always updates all four flags; others follow S.
        flag_w_raw = dp.is_cmp ? 2'b11 : {s_bit, s_bit & dp.arith};
        if (dp.is_cmp) begin
          done_raw = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d  = ALUWB;
        end
      end

      ALUWB: begin
        resultSrc = RES_ALUOUT;
        reg_w_raw = 1'b1;
        pcs_raw   = rd_is_pc;
        done_raw  = 1'b1;
        state_d   = FETCH;
      end

      MEMADR: begin
        aluSrcB = SRCB_IMM;
        state_d = s_bit ? MEMRD : MEMWR;
      end

      MEMRD: begin
        adrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end

      MEMWB: begin
        resultSrc = RES_RDATA;
        reg_w_raw = 1'b1;
        pcs_raw   = rd_is_pc;
        done_raw  = 1'b1;
        state_d   = FETCH;
      end

      MEMWR: begin
        adrSrc    = 1'b1;
        mem_w_raw = 1'b1;
        done_raw  = mem_ready;
        if (mem_ready) state_d = FETCH;
      end

      BRANCH: begin
        aluSrcB   = SRCB_IMM;
        resultSrc = RES_ALU;
        pcs_raw   = 1'b1;
        done_raw  = 1'b1;
        state_d   = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

  assign immSrc     = op;
  assign regSrc     = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

  assign irWrite    = ir_write_raw & ~rst;
  assign nextPC     = next_pc_raw  & ~rst;
  assign pcs        = pcs_raw      & ~rst;
  assign regW       = reg_w_raw    & ~rst;
  assign memW       = mem_w_raw    & ~rst;
  assign flagW      = flag_w_raw   & {2{~rst}};
  assign illegal    = illegal_raw  & ~rst;
  assign instr_done = done_raw     & ~rst;

  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each instruction is planned as a list of steps from the
// per-class latency rules; a negedge compare process checks every output each cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mem_ready;
  logic       irWrite, nextPC, adrSrc, aluSrcA;
  logic [1:0] aluSrcB, aluControl, resultSrc, immSrc, regSrc;
  logic       pcs, regW, memW;
  logic [1:0] flagW;
  logic       illegal, instr_done;
  logic [3:0] state_o;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .rd(rd), .mem_ready(mem_ready),
    .irWrite(irWrite), .nextPC(nextPC), .adrSrc(adrSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .resultSrc(resultSrc),
    .immSrc(immSrc), .regSrc(regSrc), .pcs(pcs), .regW(regW), .memW(memW),
    .flagW(flagW), .illegal(illegal), .instr_done(instr_done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ILL, K_DPR, K_DPI, K_CMP, K_LDR, K_STR, K_B} kind_e;

  typedef struct packed {
    logic [3:0] st;
    logic       ir_write, next_pc, adr_src, alu_src_a;
    logic [1:0] alu_src_b, alu_control, result_src, imm_src, reg_src;
    logic       pcs, reg_w, mem_w;
    logic [1:0] flag_w;
    logic       illegal, instr_done;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cur_step = 0;
  bit model_on = 1'b0;
  bit rec_on   = 1'b0;
  bit rnd_ready = 1'b0;
  bit ready_q[$];
  int seen_st[$], seen_regw[$], seen_memw[$], seen_done[$], seen_ill[$], seen_flagw[$], seen_pcs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string name, input int got[$], input int exp[$]);
    check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(exp[i]));
  endtask

  function automatic bit cmd_supported(input logic [3:0] c);
    return c inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] c);
    case (c)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b1010: return 2'b01;
      4'b0000: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic kind_e classify(input logic [1:0] o, input logic [5:0] f);
    case (o)
      2'b00: begin
        if (!cmd_supported(f[4:1])) return K_ILL;
        if (f[4:1] == 4'b1010)      return K_CMP;
        return f[5] ? K_DPI : K_DPR;
      end
      2'b01:   return f[0] ? K_LDR : K_STR;
      2'b10:   return K_B;
      default: return K_ILL;
    endcase
  endfunction

  // Expected outputs of one step (step numbers are the published state codes).
  function automatic exp_t expect_step(input int step, input logic [1:0] o, input logic [5:0] f,
                                       input logic [3:0] r, input logic rdy);
    exp_t e;
    bit   is_cmp;
    e = '0;
    e.st      = 4'(step);
    e.imm_src = o;
    e.reg_src = {(o == 2'b01) && !f[0], (o == 2'b10)};
    is_cmp    = (f[4:1] == 4'b1010);
    case (step)
      0: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
               e.ir_write = rdy; e.next_pc = rdy; end
      1: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
               e.illegal = (classify(o, f) == K_ILL); end
      6, 7: begin
        e.alu_src_b   = (step == 7) ? 2'b01 : 2'b00;
        e.alu_control = alu_of(f[4:1]);
        e.flag_w      = is_cmp ? 2'b11 : {f[0], f[0] && (f[4:1] inside {4'b0100, 4'b0010})};
        e.instr_done  = is_cmp;
      end
      8: begin e.reg_w = 1; e.pcs = (r == 4'd15); e.instr_done = 1; end
      2: begin e.alu_src_b = 2'b01; end
      3: begin e.adr_src = 1; end
      4: begin e.result_src = 2'b01; e.reg_w = 1; e.pcs = (r == 4'd15); e.instr_done = 1; end
      5: begin e.adr_src = 1; e.mem_w = 1; e.instr_done = rdy; end
      9: begin e.alu_src_b = 2'b01; e.result_src = 2'b10; e.pcs = 1; e.instr_done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_state",   32'(state_o),   32'(0));
      check("rst_irWrite", 32'(irWrite),   32'(0));
      check("rst_nextPC",  32'(nextPC),    32'(0));
      check("rst_pcs",     32'(pcs),       32'(0));
      check("rst_regW",    32'(regW),      32'(0));
      check("rst_memW",    32'(memW),      32'(0));
      check("rst_flagW",   32'(flagW),     32'(0));
      check("rst_illegal", 32'(illegal),   32'(0));
      check("rst_done",    32'(instr_done), 32'(0));
    end else if (model_on) begin
      e = expect_step(cur_step, op, funct, rd, mem_ready);
      check("state_o",    32'(state_o),    32'(e.st));
      check("irWrite",    32'(irWrite),    32'(e.ir_write));
      check("nextPC",     32'(nextPC),     32'(e.next_pc));
      check("adrSrc",     32'(adrSrc),     32'(e.adr_src));
      check("aluSrcA",    32'(aluSrcA),    32'(e.alu_src_a));
      check("aluSrcB",    32'(aluSrcB),    32'(e.alu_src_b));
      check("aluControl", 32'(aluControl), 32'(e.alu_control));
      check("resultSrc",  32'(resultSrc),  32'(e.result_src));
      check("immSrc",     32'(immSrc),     32'(e.imm_src));
      check("regSrc",     32'(regSrc),     32'(e.reg_src));
      check("pcs",        32'(pcs),        32'(e.pcs));
      check("regW",       32'(regW),       32'(e.reg_w));
      check("memW",       32'(memW),       32'(e.mem_w));
      check("flagW",      32'(flagW),      32'(e.flag_w));
      check("illegal",    32'(illegal),    32'(e.illegal));
      check("instr_done", 32'(instr_done), 32'(e.instr_done));
      if (rec_on) begin
        seen_st.push_back(int'(state_o));
        seen_regw.push_back(int'(regW));
        seen_memw.push_back(int'(memW));
        seen_done.push_back(int'(instr_done));
        seen_ill.push_back(int'(illegal));
        seen_flagw.push_back(int'(flagW));
        seen_pcs.push_back(int'(pcs));
      end
    end
  end

  // Runs one instruction starting just after the edge that entered fetch.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input int max_steps);
    int    path[$];
    int    idx = 0;
    int    cyc = 0;
    kind_e k;
    op = o; funct = f; rd = r;
    k  = classify(o, f);
    path.push_back(0);
    path.push_back(1);
    case (k)
      K_DPR: begin path.push_back(6); path.push_back(8); end
      K_DPI: begin path.push_back(7); path.push_back(8); end
      K_CMP: path.push_back(f[5] ? 7 : 6);
      K_LDR: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      K_STR: begin path.push_back(2); path.push_back(5); end
      K_B:   path.push_back(9);
      default: ;
    endcase
    while (idx < path.size() && cyc < max_steps) begin
      cur_step = path[idx];
      if (ready_q.size() > 0) mem_ready = ready_q.pop_front();
      else if (rnd_ready)     mem_ready = ($urandom_range(0, 9) < 7);
      else                    mem_ready = 1'b1;
      model_on = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (!(cur_step inside {0, 3, 5}) || mem_ready) idx++;
      if (cyc >= 64 && idx < path.size()) begin
        check("instr_timeout", 32'(idx), 32'(path.size()));
        break;
      end
    end
  endtask

  task automatic start_rec();
    seen_st.delete(); seen_regw.delete(); seen_memw.delete(); seen_done.delete();
    seen_ill.delete(); seen_flagw.delete(); seen_pcs.delete();
    rec_on = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];
    logic [3:0] cmds[5];
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100; cmds[4] = 4'b1010;

    rst = 1'b1; op = 2'b00; funct = '0; rd = '0; mem_ready = 1'b1;
    #2;
    check("reset_state0",  32'(state_o), 32'(0));
    check("reset_irWrite", 32'(irWrite), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ADD immediate into R1: fetch, decode, EXECI, ALUWB.
    start_rec();
    run_instr(2'b00, 6'b101000, 4'd1, 100);
    rec_on = 1'b0;
    exp_q = '{0, 1, 7, 8};    check_seq("addi_states", seen_st, exp_q);
    exp_q = '{0, 0, 0, 1};    check_seq("addi_regW", seen_regw, exp_q);
    check_seq("addi_done", seen_done, exp_q);

    // SUBS into R15: both flag enables in EXECR, pcs in ALUWB.
    start_rec();
    run_instr(2'b00, 6'b000101, 4'd15, 100);
    rec_on = 1'b0;
    exp_q = '{0, 1, 6, 8};    check_seq("subs_states", seen_st, exp_q);
    exp_q = '{0, 0, 3, 0};    check_seq("subs_flagW", seen_flagw, exp_q);
    exp_q = '{0, 0, 0, 1};    check_seq("subs_pcs", seen_pcs, exp_q);

    // LDR with two wait cycles in MEMRD.
    ready_q = '{1, 1, 1, 0, 0, 1};
    start_rec();
    run_instr(2'b01, 6'b011001, 4'd3, 100);
    rec_on = 1'b0;
    exp_q = '{0, 1, 2, 3, 3, 3, 4};  check_seq("ldr_states", seen_st, exp_q);
    exp_q = '{0, 0, 0, 0, 0, 0, 1};  check_seq("ldr_regW", seen_regw, exp_q);

    // STR with one wait cycle in MEMWR.
    ready_q = '{1, 1, 1, 0, 1};
    start_rec();
    run_instr(2'b01, 6'b011000, 4'd4, 100);
    rec_on = 1'b0;
    exp_q = '{0, 1, 2, 5, 5};  check_seq("str_states", seen_st, exp_q);
    exp_q = '{0, 0, 0, 1, 1};  check_seq("str_memW", seen_memw, exp_q);
    exp_q = '{0, 0, 0, 0, 1};  check_seq("str_done", seen_done, exp_q);

    // Illegal op: single-cycle pulse in decode, nothing written.
    start_rec();
    run_instr(2'b11, 6'b000000, 4'd15, 100);
    rec_on = 1'b0;
    exp_q = '{0, 1};  check_seq("ill_states", seen_st, exp_q);
    check_seq("ill_pulse", seen_ill, exp_q);
    exp_q = '{0, 0};  check_seq("ill_regW", seen_regw, exp_q);
    check_seq("ill_memW", seen_memw, exp_q);
    check_seq("ill_pcs", seen_pcs, exp_q);

    // Branch then CMP (3-cycle instructions).
    start_rec();
    run_instr(2'b10, 6'b000000, 4'd0, 100);
    run_instr(2'b00, 6'b010101, 4'd0, 100);
    rec_on = 1'b0;
    exp_q = '{0, 1, 9, 0, 1, 6};  check_seq("b_cmp_states", seen_st, exp_q);

    // Abort an ADD in EXECR with reset.
    run_instr(2'b00, 6'b001001, 4'd2, 2);
    model_on = 1'b0;
    check("abort_pre_state", 32'(state_o), 32'(6));
    mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("abort_state",   32'(state_o), 32'(0));
    check("abort_regW",    32'(regW),    32'(0));
    check("abort_flagW",   32'(flagW),   32'(0));
    check("abort_irWrite", 32'(irWrite), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random instruction mix with random memory wait cycles.
    rnd_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [1:0] o;
      logic [5:0] f;
      logic [3:0] r;
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      if (o == 2'b00 && $urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 4)];
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(o, f, r, 1000);
    end

    model_on = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
